tdc_meas_ctrl: RTL and testbench

- Measurement sequencer for the clock-based TDC path on the CAN_logic input.
- Synchronizes CAN_logic and arms a measurement on the recessive-to-dominant edge (1->0).
- Counts CLK cycles until the dominant-to-recessive edge (0->1), then filters and optionally averages the result.
- Presents the result on a valid/ready port that feeds the out_data/HEX display path. SW is the run enable.

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_edge_sync.sv | 33 +++
 rtl/tdc_meas_ctrl.sv | 158 +++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and sizing helpers for the clock-based TDC sequencer.
// The state encoding below is what appears on state_dbg.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_COUNT      = 2'd2,
    ST_HOLD       = 2'd3
  } tdc_state_e;

  localparam int CNT_W_DEF = 21;

  // Accumulator must hold 2^log2_avg full-scale samples without wrapping.
  function automatic int acc_width(input int cnt_w, input int log2_avg);
    return cnt_w + log2_avg;
  endfunction

endpackage

// File: rtl/tdc_edge_sync.sv
// tdc_edge_sync: synchronizes the asynchronous CAN level and detects edges.
// All flops reset to 1 so the bus reads recessive and no edge fires at reset.
// SYNC_STAGES must be at least 2.
module tdc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_can_async,
  output logic o_can_s,
  output logic o_fall,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_can_d;

  // Synchronizer chain plus one delay flop for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '1;
      r_can_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_can_async};
      r_can_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_can_s = r_sync[SYNC_STAGES-1];
  assign o_fall  = r_can_d & ~o_can_s;
  assign o_rise  = ~r_can_d & o_can_s;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: measures CAN_logic low time in CLK cycles.
// Arms on a synchronized falling edge, counts until the rising edge, drops
// glitches shorter than MIN_CNT and flags counter saturation (sticky).
// Optional averaging of 2^LOG2_AVG samples is enabled by defining TDC_AVG_EN.
// Output handshake: out_data is valid while out_valid=1 and is held stable
// until a cycle with out_valid=1 and out_ready=1; out_valid drops on the next
// edge. No further result is produced while one is pending.
module tdc_meas_ctrl import tdc_pkg::*; #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_CNT     = 4
`ifdef TDC_AVG_EN
  ,
  parameter int LOG2_AVG    = 3
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SW,
  input  logic             CAN_logic,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow_err,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_CNT);

  logic             w_can_s;
  logic             w_fall;
  logic             w_rise;
  logic             r_ev_fall;
  logic             r_ev_rise;
  logic             r_ev_low;
  tdc_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_ovf;

`ifdef TDC_AVG_EN
  localparam int ACC_W = acc_width(CNT_W, LOG2_AVG);
  logic [ACC_W-1:0]    r_acc;
  logic [LOG2_AVG-1:0] r_nsamp;
  logic [ACC_W-1:0]    w_acc_sum;

  assign w_acc_sum = r_acc + ACC_W'(r_cnt);
`endif

  tdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_can_async (CAN_logic),
    .o_can_s     (w_can_s),
    .o_fall      (w_fall),
    .o_rise      (w_rise)
  );

  // Register edge events and level together so they stay cycle-aligned
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ev_fall <= 1'b0;
      r_ev_rise <= 1'b0;
      r_ev_low  <= 1'b0;
    end else begin
      r_ev_fall <= w_fall;
      r_ev_rise <= w_rise;
      r_ev_low  <= ~w_can_s;
    end
  end

  // Sequencer: arm on fall, count low time, filter, publish and hold
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef TDC_AVG_EN
      r_acc       <= '0;
      r_nsamp     <= '0;
`endif
    end else begin
`ifdef TDC_AVG_EN
      if (!SW) begin
        r_acc   <= '0;
        r_nsamp <= '0;
      end
`endif
      case (r_state)
        ST_IDLE: begin
          if (!SW) r_ovf   <= 1'b0;
          else     r_state <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (!SW) begin
            r_state <= ST_IDLE;
          end else if (r_ev_fall) begin
            r_cnt   <= CNT_W'(1);
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!SW) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_MAX) begin
            // Saturation wins over a simultaneous rise
            r_ovf   <= 1'b1;
            r_state <= ST_WAIT_START;
          end else if (r_ev_rise) begin
            if (r_cnt < MIN_L) begin
              r_state <= ST_WAIT_START;
            end else begin
`ifdef TDC_AVG_EN
              if (&r_nsamp) begin
                r_out_data  <= w_acc_sum[ACC_W-1:LOG2_AVG];
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_nsamp     <= '0;
                r_state     <= ST_HOLD;
              end else begin
                r_acc       <= w_acc_sum;
                r_nsamp     <= r_nsamp + LOG2_AVG'(1);
                r_state     <= ST_WAIT_START;
              end
`else
              r_out_data  <= r_cnt;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
`endif
            end
          end else if (r_ev_low) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= SW ? ST_WAIT_START : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign overflow_err = r_ovf;
  assign state_dbg    = r_state;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: self-checking bench for tdc_meas_ctrl (CNT_W=8).
// Expected results come from pulse lengths: a pulse of L cycles yields L when
// MIN_CNT <= L < 2^CNT_W-1, otherwise nothing (L >= 2^CNT_W-1 sets overflow).
// With TDC_AVG_EN the model sums accepted lengths and emits sum>>LOG2_AVG.
`timescale 1ns/1ps
module tb_tdc_meas_ctrl;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MIN_CNT     = 4;
  localparam int LOG2_AVG    = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sw;
  logic             can;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             overflow_err;
  logic [1:0]       state_dbg;

  int               total = 0;
  int               bad = 0;
  int               hs_cnt = 0;
  int               acc_sum = 0;
  int               acc_n = 0;
  bit               rnd_ready = 1'b0;
  logic [CNT_W-1:0] exp_q[$];

  // Clock and DUT
  always #5 clk = ~clk;

  tdc_meas_ctrl #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_CNT     (MIN_CNT)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .SW           (sw),
    .CAN_logic    (can),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overflow_err (overflow_err),
    .state_dbg    (state_dbg)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) check_val("unexpected_result_qsize", exp_q.size(), 1);
      else check_val("result_data", out_data, exp_q.pop_front());
    end
  end

  // Drivers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_accept(input int len);
`ifdef TDC_AVG_EN
    acc_sum += len;
    acc_n++;
    if (acc_n == (1 << LOG2_AVG)) begin
      exp_q.push_back(CNT_W'(acc_sum >> LOG2_AVG));
      acc_sum = 0;
      acc_n   = 0;
    end
`else
    exp_q.push_back(CNT_W'(len));
`endif
  endtask

  task automatic set_sw(input logic v);
    sw = v;
    if (!v) begin
      acc_sum = 0;
      acc_n   = 0;
    end
  endtask

  // Low pulse of exactly len sampled cycles, then gap high cycles
  task automatic send_pulse(input int len, input int gap);
    can = 1'b0;
    tick(len);
    can = 1'b1;
    if (len >= MIN_CNT && len < CNT_MAX) model_accept(len);
    tick(gap);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) check_val("wait_valid_timeout", out_valid, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (out_valid && n < 400) begin
      tick(1);
      n++;
    end
    if (out_valid) check_val("drain_timeout", out_valid, 0);
    tick(2);
  endtask

  int lat;
  int hs0;

  initial begin
    rst = 1'b1; sw = 1'b0; can = 1'b1; out_ready = 1'b1;
    tick(3);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", overflow_err, 0);
    check_val("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick(2);
    check_val("idle_state", state_dbg, 0);
    set_sw(1'b1);
    tick(1);
    check_val("wait_state", state_dbg, 1);
    check_val("wait_busy", busy, 1);
    tick(3);

`ifndef TDC_AVG_EN
    // Basic 100-cycle measurement with latency
    hs0 = hs_cnt;
    can = 1'b0;
    tick(100);
    can = 1'b1;
    model_accept(100);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", lat, SYNC_STAGES + 2);
    check_val("basic_data", out_data, 100);
    tick(1);
    check_val("basic_valid_drop", out_valid, 0);
    check_val("basic_busy", busy, 1);
    check_val("basic_state", state_dbg, 1);
    tick(5);
    check_val("basic_hs", hs_cnt - hs0, 1);

    // Glitch filter
    hs0 = hs_cnt;
    send_pulse(3, 12);
    check_val("glitch_no_valid", hs_cnt - hs0, 0);
    send_pulse(50, 12);
    wait_drain();
    check_val("glitch_then_50_hs", hs_cnt - hs0, 1);

    // Backpressure: pending result holds, further pulses are dropped
    out_ready = 1'b0;
    hs0 = hs_cnt;
    send_pulse(100, 0);
    wait_valid(lat);
    for (int i = 0; i < 40; i++) begin
      can = ((i % 25) < 20) ? 1'b0 : 1'b1;
      tick(1);
      check_val("bp_data_hold", out_data, 100);
      check_val("bp_valid_hold", out_valid, 1);
    end
    can = 1'b1;
    tick(10);
    check_val("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(30);
    check_val("bp_single_hs", hs_cnt - hs0, 1);

    // Abort mid-pulse
    hs0 = hs_cnt;
    can = 1'b0;
    tick(30);
    set_sw(1'b0);
    tick(1);
    check_val("abort_state", state_dbg, 0);
    check_val("abort_busy", busy, 0);
    tick(10);
    can = 1'b1;
    tick(20);
    check_val("abort_no_valid", hs_cnt - hs0, 0);
    set_sw(1'b1);
    tick(3);

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    send_pulse(40, 0);
    wait_valid(lat);
    tick(1);
    rst = 1'b1;
    #1;
    check_val("rst_hold_valid", out_valid, 0);
    check_val("rst_hold_data", out_data, 0);
    check_val("rst_hold_state", state_dbg, 0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check_val("post_rst_state", state_dbg, 1);
`else
    // Averaging: eight pulses 10..17 with a short glitch inserted
    hs0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      send_pulse(10 + i, 12);
      if (i == 3) send_pulse(3, 12);
      wait_drain();
    end
    check_val("avg_single_hs", hs_cnt - hs0, 1);

    // Abort clears the partial average
    can = 1'b0;
    tick(30);
    set_sw(1'b0);
    tick(1);
    check_val("abort_state", state_dbg, 0);
    check_val("abort_busy", busy, 0);
    can = 1'b1;
    tick(10);
    set_sw(1'b1);
    tick(3);
`endif

    // Overflow: sticky through measurements, cleared in idle with SW=0
    hs0 = hs_cnt;
    send_pulse(300, 12);
    check_val("ovf_set", overflow_err, 1);
    check_val("ovf_no_valid", hs_cnt - hs0, 0);
    send_pulse(60, 12);
    wait_drain();
    check_val("ovf_sticky", overflow_err, 1);
`ifndef TDC_AVG_EN
    out_ready = 1'b0;
    send_pulse(40, 0);
    wait_valid(lat);
    set_sw(1'b0);
    tick(3);
    check_val("hold_sw0_valid", out_valid, 1);
    check_val("hold_sw0_state", state_dbg, 3);
    check_val("hold_sw0_ovf", overflow_err, 1);
    out_ready = 1'b1;
    tick(1);
    check_val("hold_exit_idle", state_dbg, 0);
    tick(1);
    check_val("ovf_cleared", overflow_err, 0);
`else
    set_sw(1'b0);
    tick(2);
    check_val("ovf_cleared", overflow_err, 0);
`endif
    set_sw(1'b1);
    tick(3);

    // Randomized pulses with random consumer stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send_pulse($urandom_range(1, 150), $urandom_range(8, 20));
      wait_drain();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    tick(10);
    check_val("leftover_expected", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
